// File: rtl/lat_cfg_ctrl_pkg.sv
// Shared definitions for the look-at-table configuration sequencer:
// state encodings, sync word, frame geometry and payload field offsets.
package lat_cfg_ctrl_pkg;

    localparam int unsigned W_ST       = 5;
    localparam int unsigned N_ST       = 5;
    localparam int unsigned SYNC_W     = 5;
    localparam int unsigned FRAME_BITS = 2 + N_ST * W_ST;   // 27
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned HOLD_W     = 4;

    localparam logic [SYNC_W-1:0] SYNC_WORD = 5'b01010;

    // Payload bit offsets; out_sel is the first bit received, so it lands at the MSB.
    localparam int unsigned OFF_OUT_SEL = 26;
    localparam int unsigned OFF_CLK_SEL = 25;
    localparam int unsigned OFF_JUMP1   = 20;
    localparam int unsigned OFF_JUMP2   = 15;
    localparam int unsigned OFF_JUMP3   = 10;
    localparam int unsigned OFF_JUMP4   = 5;
    localparam int unsigned OFF_JUMP5   = 0;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        LOAD = 3'd1,
        PAR  = 3'd2,
        HOLD = 3'd3,
        ERR  = 3'd4
    } state_e;

    typedef struct packed {
        logic            out_sel;
        logic            clk_sel;
        logic [W_ST-1:0] jump1;
        logic [W_ST-1:0] jump2;
        logic [W_ST-1:0] jump3;
        logic [W_ST-1:0] jump4;
        logic [W_ST-1:0] jump5;
    } cfg_t;

    // Split a received payload into its configuration fields.
    function automatic cfg_t decode_frame(input logic [FRAME_BITS-1:0] p);
        cfg_t c;
        c.out_sel = p[OFF_OUT_SEL];
        c.clk_sel = p[OFF_CLK_SEL];
        c.jump1   = p[OFF_JUMP1 +: W_ST];
        c.jump2   = p[OFF_JUMP2 +: W_ST];
        c.jump3   = p[OFF_JUMP3 +: W_ST];
        c.jump4   = p[OFF_JUMP4 +: W_ST];
        c.jump5   = p[OFF_JUMP5 +: W_ST];
        return c;
    endfunction

endpackage

// File: rtl/lat_cfg_shreg.sv
// Payload deserialiser: enabled MSB-first shift register with a running
// XOR parity accumulator and a synchronous clear.
module lat_cfg_shreg
    import lat_cfg_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  shift_en,
    input  logic                  din,
    output logic [FRAME_BITS-1:0] data,
    output logic                  parity
);

    logic [FRAME_BITS-1:0] data_q, data_d;
    logic                  par_q,  par_d;

    // Next-state: clear wins over shift; parity tracks every bit shifted in.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        data_d = data_q;
        par_d  = par_q;
        if (clr) begin
            data_d = '0;
            par_d  = 1'b0;
        end else if (shift_en) begin
            data_d = {data_q[FRAME_BITS-2:0], din};
            par_d  = par_q ^ din;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            data_q <= '0;
            par_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            par_q  <= par_d;
        end
    end

    assign data   = data_q;
    assign parity = par_q;

endmodule

// File: rtl/lat_cfg_ctrl.sv
// Serial configuration sequencer: hunts the sync word, deserialises a
// parity-protected frame, commits shadow registers and freezes the FSM
// while the clock mux settles.
module lat_cfg_ctrl
    import lat_cfg_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic            clk_in,
    input  logic            reset,
    input  logic            ser_in,
    input  logic            ser_en,
    input  logic            abort,
    output logic [W_ST-1:0] jump1,
    output logic [W_ST-1:0] jump2,
    output logic [W_ST-1:0] jump3,
    output logic [W_ST-1:0] jump4,
    output logic [W_ST-1:0] jump5,
    output logic            clk_sel,
    output logic            out_sel,
    output logic            cfg_ok,
    output logic            cfg_err,
    output logic            fsm_hold,
    output logic            busy
);

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_BITS - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYC - 1);

    state_e            state_q,    state_d;
    // Only the last four bits need storing: the fifth is the bit arriving now.
    logic [SYNC_W-2:0] sync_sr_q,  sync_sr_d;
    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    cfg_t              cfg_q,      cfg_d;
    logic              cfg_ok_q,   cfg_ok_d;
    logic              cfg_err_q,  cfg_err_d;
    logic              fsm_hold_q, fsm_hold_d;

    logic [FRAME_BITS-1:0] payload;
    logic                  par_acc;
    logic                  sr_clr;
    logic                  sr_shift;

    // Payload is held clear while hunting and discarded on abort.
    assign sr_clr   = (state_q == HUNT) || abort;
    assign sr_shift = (state_q == LOAD) && ser_en && !abort;

    lat_cfg_shreg u_shreg (
        .clk      (clk_in),
        .rst_n    (reset),
        .clr      (sr_clr),
        .shift_en (sr_shift),
        .din      (ser_in),
        .data     (payload),
        .parity   (par_acc)
    );

    // Next-state and shadow-register update logic.
    always_comb begin
        state_d    = state_q;
        sync_sr_d  = sync_sr_q;
        bit_cnt_d  = bit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        cfg_d      = cfg_q;
        cfg_ok_d   = cfg_ok_q;
        cfg_err_d  = 1'b0;
        fsm_hold_d = fsm_hold_q;

        unique case (state_q)
            HUNT: begin
                if (abort) begin
                    sync_sr_d = '0;
                end else if (ser_en) begin
                    if ({sync_sr_q, ser_in} == SYNC_WORD) begin
                        state_d   = LOAD;
                        bit_cnt_d = '0;
                        sync_sr_d = '0;
                    end else begin
                        sync_sr_d = {sync_sr_q[SYNC_W-3:0], ser_in};
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = HUNT;
                end else if (ser_en) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = PAR;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (abort) begin
                    state_d = HUNT;
                end else if (ser_en) begin
                    if ((par_acc ^ ser_in) == 1'b0) begin
                        state_d    = HOLD;
                        cfg_d      = decode_frame(payload);
                        cfg_ok_d   = 1'b1;
                        fsm_hold_d = 1'b1;
                        hold_cnt_d = HOLD_INIT;
                    end else begin
                        state_d   = ERR;
                        cfg_err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (abort || (hold_cnt_q == '0)) begin
                    fsm_hold_d = 1'b0;
                    state_d    = HUNT;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            ERR: begin
                state_d = HUNT;
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State, counter and shadow registers; reset clears committed config too.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q    <= HUNT;
            sync_sr_q  <= '0;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            cfg_q      <= '0;
            cfg_ok_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
            fsm_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_sr_q  <= sync_sr_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            cfg_q      <= cfg_d;
            cfg_ok_q   <= cfg_ok_d;
            cfg_err_q  <= cfg_err_d;
            fsm_hold_q <= fsm_hold_d;
        end
    end

    assign jump1    = cfg_q.jump1;
    assign jump2    = cfg_q.jump2;
    assign jump3    = cfg_q.jump3;
    assign jump4    = cfg_q.jump4;
    assign jump5    = cfg_q.jump5;
    assign clk_sel  = cfg_q.clk_sel;
    assign out_sel  = cfg_q.out_sel;
    assign cfg_ok   = cfg_ok_q;
    assign cfg_err  = cfg_err_q;
    assign fsm_hold = fsm_hold_q;
    assign busy     = (state_q == LOAD) || (state_q == PAR) || (state_q == HOLD);

endmodule

// File: tb/tb_lat_cfg_ctrl.sv
// Scoreboard bench for lat_cfg_ctrl: stimulus pushes expected commit/error
// events, a negedge monitor pops and compares when fsm_hold rises or cfg_err pulses.
module tb_lat_cfg_ctrl;

    localparam int HOLD_CYC = 4;

    // Frame 1: out_sel=1, clk_sel=0, jumps 1..5 (even weight -> parity 0)
    localparam logic [26:0] F1 = {1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    // Frame B: out_sel=0, clk_sel=1, jumps 31,0,31,0,31 (even weight -> parity 0)
    localparam logic [26:0] FB = {1'b0, 1'b1, 5'd31, 5'd0, 5'd31, 5'd0, 5'd31};

    logic       clk_in = 1'b0;
    logic       reset  = 1'b0;
    logic       ser_in = 1'b0;
    logic       ser_en = 1'b0;
    logic       abort  = 1'b0;
    logic [4:0] jump1, jump2, jump3, jump4, jump5;
    logic       clk_sel, out_sel, cfg_ok, cfg_err, fsm_hold, busy;

    lat_cfg_ctrl #(.HOLD_CYC(HOLD_CYC)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .ser_in   (ser_in),
        .ser_en   (ser_en),
        .abort    (abort),
        .jump1    (jump1),
        .jump2    (jump2),
        .jump3    (jump3),
        .jump4    (jump4),
        .jump5    (jump5),
        .clk_sel  (clk_sel),
        .out_sel  (out_sel),
        .cfg_ok   (cfg_ok),
        .cfg_err  (cfg_err),
        .fsm_hold (fsm_hold),
        .busy     (busy)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [26:0] cfg;
        logic        ok;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [26:0] model_cfg = '0;
    logic        model_ok  = 1'b0;
    int          n_checks  = 0;
    int          n_fail    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [26:0] dut_cfg();
        return {out_sel, clk_sel, jump1, jump2, jump3, jump4, jump5};
    endfunction

    task automatic check_pop(input bit is_err);
        exp_t e;
        check(is_err ? "sb_has_err" : "sb_has_commit", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check(is_err ? "event_is_err" : "event_is_commit", 32'(is_err), 32'(e.is_err));
            check("cfg_fields", 32'(dut_cfg()), 32'(e.cfg));
            check("cfg_ok", 32'(cfg_ok), 32'(e.ok));
            check("latency", cyc, e.cyc);
        end
    endtask

    // Monitor
    logic hold_prev = 1'b0;
    logic err_prev  = 1'b0;
    int   hold_len  = 0;

    always @(negedge clk_in) begin
        if (!reset) begin
            hold_prev <= 1'b0;
            err_prev  <= 1'b0;
            hold_len  <= 0;
        end else begin
            if (cfg_err) begin
                check("err_width", 32'(err_prev), 0);
                check_pop(1'b1);
            end
            if (fsm_hold && !hold_prev) begin
                hold_len <= 1;
                check_pop(1'b0);
            end else if (fsm_hold) begin
                hold_len <= hold_len + 1;
            end else if (hold_prev) begin
                check("hold_len", hold_len, HOLD_CYC);
            end
            hold_prev <= fsm_hold;
            err_prev  <= cfg_err;
        end
    end

    // Stimulus helpers
    task automatic send_bit(input logic b, input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (g) begin
            @(posedge clk_in);
            #1;
        end
        ser_in = b;
        ser_en = 1'b1;
        @(posedge clk_in);
        #1;
        ser_en = 1'b0;
        ser_in = 1'b0;
    endtask

    task automatic send_sync(input int max_gap);
        logic [4:0] s;
        s = 5'b01010;
        for (int i = 4; i >= 0; i--) send_bit(s[i], max_gap);
    endtask

    task automatic push_exp(input bit is_err, input logic [26:0] p);
        exp_t e;
        if (!is_err) begin
            model_cfg = p;
            model_ok  = 1'b1;
        end
        e.is_err = is_err;
        e.cfg    = model_cfg;
        e.ok     = model_ok;
        e.cyc    = cyc;
        sb_q.push_back(e);
    endtask

    task automatic send_frame(input logic [26:0] p, input logic bad_par, input int max_gap);
        send_sync(max_gap);
        for (int i = 26; i >= 0; i--) send_bit(p[i], max_gap);
        send_bit((^p) ^ bad_par, max_gap);
        push_exp(bad_par, p);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk_in);
        check("sb_drain", sb_q.size(), 0);
        sb_q.delete();
        repeat (HOLD_CYC + 2) @(posedge clk_in);
        #1;
        check("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        logic [26:0] p;
        logic [6:0]  s;

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_outputs",
              {jump1, jump2, jump3, jump4, jump5, clk_sel, out_sel, cfg_ok, cfg_err, fsm_hold, busy}, 0);
        reset = 1'b1;
        @(posedge clk_in);
        #1;

        // Bad parity: error pulse, nothing committed
        send_frame(F1, 1'b1, 0);
        drain();
        check("bad_par_cfg_ok", 32'(cfg_ok), 0);

        // Good frame 1
        send_frame(F1, 1'b0, 0);
        drain();
        check("f1_cfg_ok", 32'(cfg_ok), 1);

        // Second frame overwrites
        send_frame(FB, 1'b0, 0);
        drain();

        // Abort after 10 payload bits, then full frame 1
        p = FB;
        send_sync(0);
        for (int i = 26; i >= 17; i--) send_bit(p[i], 0);
        check("pre_abort_busy", 32'(busy), 1);
        abort = 1'b1;
        @(posedge clk_in);
        #1;
        abort = 1'b0;
        check("post_abort_busy", 32'(busy), 0);
        send_frame(F1, 1'b0, 0);
        drain();

        // Frame B then frame 1 with random 0..7 cycle gaps
        send_frame(FB, 1'b0, 0);
        drain();
        send_frame(F1, 1'b0, 7);
        drain();

        // Overlap: stream 0101010, sync on 5th bit, trailing "10" are payload bits
        send_frame(FB, 1'b0, 0);
        drain();
        s = 7'b0101010;
        for (int i = 6; i >= 3; i--) send_bit(s[i], 0);
        check("overlap_busy_bit4", 32'(busy), 0);
        send_bit(s[2], 0);
        check("overlap_busy_bit5", 32'(busy), 1);
        send_bit(s[1], 0);
        send_bit(s[0], 0);
        p = F1;
        for (int i = 24; i >= 0; i--) send_bit(p[i], 0);
        send_bit(^p, 0);
        push_exp(1'b0, p);
        drain();

        // Reset mid-LOAD after a prior commit
        p = FB;
        send_sync(0);
        for (int i = 26; i >= 17; i--) send_bit(p[i], 0);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs",
              {jump1, jump2, jump3, jump4, jump5, clk_sel, out_sel, cfg_ok, cfg_err, fsm_hold, busy}, 0);
        model_cfg = '0;
        model_ok  = 1'b0;
        @(posedge clk_in);
        #1;
        reset = 1'b1;
        @(posedge clk_in);
        #1;
        check("post_reset_busy", 32'(busy), 0);
        send_frame(FB, 1'b0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
